// File: rtl/fifo_occupancy.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_occupancy: synchronous FWFT FIFO with occupancy count, programmable   |
// | almost-full/almost-empty thresholds and a sticky misuse flag.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fifo_occupancy #(
  parameter int width_p        = 27,
  parameter int lg_depth_p     = 3,
  parameter int almost_full_p  = 6,
  parameter int almost_empty_p = 1
) (
  input  logic                  clk,
  input  logic                  reset_n_i,
  input  logic                  clear_i,
  input  logic [width_p-1:0]    d_i,
  input  logic                  enque_i,
  input  logic                  deque_i,
  output logic [width_p-1:0]    d_o,
  output logic                  valid_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [lg_depth_p:0]   count_o,
  output logic                  error_o
);

  localparam int                  c_depth     = 1 << lg_depth_p;
  localparam logic [lg_depth_p:0] c_depth_cnt = (lg_depth_p+1)'(c_depth);
  localparam logic [lg_depth_p:0] c_af_cnt    = (lg_depth_p+1)'(almost_full_p);
  localparam logic [lg_depth_p:0] c_ae_cnt    = (lg_depth_p+1)'(almost_empty_p);
  localparam logic [lg_depth_p-1:0] c_ptr_one = lg_depth_p'(1);
  localparam logic [lg_depth_p:0]   c_cnt_one = (lg_depth_p+1)'(1);

  logic [width_p-1:0]    r_mem [c_depth];
  logic [lg_depth_p-1:0] r_rptr;
  logic [lg_depth_p-1:0] r_wptr;
  logic [lg_depth_p:0]   r_count;
  logic                  r_error;

  logic w_enq_ok;
  logic w_deq_ok;
  logic w_misuse;

  // Flags come only from the count so the full/empty corner is unambiguous.
  assign empty_o        = (r_count == '0);
  assign valid_o        = (r_count != '0);
  assign full_o         = (r_count == c_depth_cnt);
  assign almost_full_o  = (r_count >= c_af_cnt);
  assign almost_empty_o = (r_count <= c_ae_cnt);
  assign count_o        = r_count;
  assign error_o        = r_error;
  assign d_o            = r_mem[r_rptr];

  assign w_enq_ok = enque_i & (~full_o | deque_i);
  assign w_deq_ok = deque_i & ~empty_o;
  assign w_misuse = (enque_i & full_o & ~deque_i) | (deque_i & empty_o);

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      r_error <= 1'b0;
    end else if (clear_i) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      r_error <= 1'b0;
    end else begin
      if (w_enq_ok) r_wptr <= r_wptr + c_ptr_one;
      if (w_deq_ok) r_rptr <= r_rptr + c_ptr_one;
      if (w_enq_ok && !w_deq_ok) begin
        r_count <= r_count + c_cnt_one;
      end else if (!w_enq_ok && w_deq_ok) begin
        r_count <= r_count - c_cnt_one;
      end
      r_error <= r_error | w_misuse;
    end
  end

  // Storage has no reset; contents are don't-care after reset or clear.
  always_ff @(posedge clk) begin
    if (!clear_i && w_enq_ok) begin
      r_mem[r_wptr] <= d_i;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset_n_i && !clear_i) begin
      if (enque_i && full_o && !deque_i) $display("error: wrote full fifo");
      if (deque_i && empty_o)            $display("error: deque empty fifo");
    end
  end

  if (almost_full_p < 1 || almost_full_p > c_depth) begin : g_af_range_check
    $error("fifo_occupancy: almost_full_p out of range");
  end
  if (almost_empty_p < 0 || almost_empty_p > c_depth - 1) begin : g_ae_range_check
    $error("fifo_occupancy: almost_empty_p out of range");
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_occupancy.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fifo_occupancy: directed + random bench with a queue reference model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fifo_occupancy;

  localparam int W     = 27;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset_n_i;
  logic          clear_i;
  logic [W-1:0]  d_i;
  logic          enque_i;
  logic          deque_i;
  logic [W-1:0]  d_o;
  logic          valid_o;
  logic          empty_o;
  logic          full_o;
  logic          almost_full_o;
  logic          almost_empty_o;
  logic [3:0]    count_o;
  logic          error_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] model_q[$];
  logic         model_err;

  fifo_occupancy dut (
    .clk            (clk),
    .reset_n_i      (reset_n_i),
    .clear_i        (clear_i),
    .d_i            (d_i),
    .enque_i        (enque_i),
    .deque_i        (deque_i),
    .d_o            (d_o),
    .valid_o        (valid_o),
    .empty_o        (empty_o),
    .full_o         (full_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .count_o        (count_o),
    .error_o        (error_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int sz;
    sz = model_q.size();
    chk({tag, ".count"}, 32'(count_o), 32'(sz));
    chk({tag, ".empty"}, 32'(empty_o), 32'(sz == 0));
    chk({tag, ".valid"}, 32'(valid_o), 32'(sz != 0));
    chk({tag, ".full"},  32'(full_o),  32'(sz == DEPTH));
    chk({tag, ".afull"}, 32'(almost_full_o),  32'(sz >= 6));
    chk({tag, ".aempty"},32'(almost_empty_o), 32'(sz <= 1));
    chk({tag, ".error"}, 32'(error_o), 32'(model_err));
    if (sz != 0) chk({tag, ".d_o"}, 32'(d_o), 32'(model_q[0]));
  endtask

  // One clock cycle of stimulus; the model applies the queue rules directly.
  task automatic step(input string tag, input logic e, input logic d, input logic c,
                      input logic [W-1:0] data);
    bit was_full, was_empty;
    @(negedge clk);
    enque_i = e; deque_i = d; clear_i = c; d_i = data;
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
    if (c) begin
      model_q.delete();
      model_err = 1'b0;
    end else begin
      if ((e && was_full && !d) || (d && was_empty)) model_err = 1'b1;
      if (d && !was_empty) void'(model_q.pop_front());
      if (e && (!was_full || d)) model_q.push_back(data);
    end
    @(posedge clk);
    #1;
    enque_i = 1'b0; deque_i = 1'b0; clear_i = 1'b0;
    check_outputs(tag);
  endtask

  initial begin
    reset_n_i = 1'b0; clear_i = 1'b0; d_i = '0; enque_i = 1'b0; deque_i = 1'b0;
    model_err = 1'b0;
    #2;
    check_outputs("reset");
    @(negedge clk);
    reset_n_i = 1'b1;

    // Fill 0x1..0x8.
    for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, 1'b0, 1'b0, W'(i));
    // Drain in order.
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 1'b1, 1'b0, '0);

    // Overflow: refill, push 0xAA with no dequeue, then drain.
    for (int i = 1; i <= DEPTH; i++) step("refill", 1'b1, 1'b0, 1'b0, W'(i));
    step("overflow", 1'b1, 1'b0, 1'b0, W'(32'hAA));
    for (int i = 0; i < DEPTH; i++) step("ovf_drain", 1'b0, 1'b1, 1'b0, '0);
    step("clear1", 1'b0, 1'b0, 1'b1, '0);

    // Full pass-through.
    for (int i = 1; i <= DEPTH; i++) step("fill2", 1'b1, 1'b0, 1'b0, W'(i));
    step("passthru", 1'b1, 1'b1, 1'b0, W'(9));
    for (int i = 0; i < DEPTH; i++) step("pt_drain", 1'b0, 1'b1, 1'b0, '0);

    // Empty corner then clear.
    step("empty_both", 1'b1, 1'b1, 1'b0, W'(5));
    step("clear2", 1'b0, 1'b0, 1'b1, '0);

    // Interleaved random traffic crossing the pointer wrap several times.
    for (int i = 0; i < 20; i++)
      step("wrap", 1'(i % 2 == 0 || $urandom_range(0, 1) == 1), 1'(i % 2 == 1),
           1'b0, W'($urandom));
    for (int i = 0; i < 150; i++) begin
      logic e, d;
      e = ($urandom_range(0, 99) < ((i / 25) % 2 == 0 ? 75 : 30));
      d = ($urandom_range(0, 99) < ((i / 25) % 2 == 0 ? 30 : 75));
      step("rand", e, d, 1'($urandom_range(0, 60) == 0), W'($urandom));
    end
    for (int i = 0; i < 5; i++) step("preload", 1'b1, 1'b0, 1'b0, W'($urandom));
    step("set_err_pre", 1'b0, 1'b0, 1'b0, '0);

    // Asynchronous reset between edges.
    @(negedge clk);
    #1;
    reset_n_i = 1'b0;
    model_q.delete();
    model_err = 1'b0;
    #1;
    check_outputs("async_rst");
    #1;
    reset_n_i = 1'b1;
    step("post_rst_idle", 1'b0, 1'b0, 1'b0, '0);
    step("post_rst_deq", 1'b0, 1'b1, 1'b0, '0);
    step("post_rst_enq", 1'b1, 1'b0, 1'b0, W'(32'h123));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
